// File: rtl/combo_lock_sequencer_if.sv
// Pin bundle of the combination-lock user slot, without clock and reset.
// io_in[4:2] digit, io_in[5] enter, io_in[6] prog, io_in[7] clear.
// io_out[0] unlocked, [1] lockout, [2] busy, [3] error, [4] prog_active, [7:5] fail_cnt.
interface combo_lock_sequencer_if;
  logic [7:2] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/combo_lock_sequencer.sv
// Combination-lock sequencer: collects 3-bit digits on enter rising edges, checks them
// against a stored code, counts failed attempts with a timed lockout, and allows the
// code to be reprogrammed while unlocked.
// Ports: clk, rst_n (synchronous, active-low), pins (slave side of combo_lock_sequencer_if).
// Latency: enter pin edge to outputs is two clocks; no backpressure, digits are never stalled.
// Optional feature: define AUTO_RELOCK_EN to fall back to IDLE after RELOCK_CYCLES idle clocks.
module combo_lock_sequencer #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [3*CODE_LEN-1:0] RESET_CODE     = 12'b001_010_011_100,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 16,
  parameter int                    RELOCK_CYCLES  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  combo_lock_sequencer_if.slave pins
);
  localparam int              CW         = 3 * CODE_LEN;
  localparam int              TW         = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0]      IDX_LAST   = 3'(CODE_LEN - 1);
  localparam logic [2:0]      FAIL_LAST  = 3'(MAX_FAILS - 1);
  localparam logic [2:0]      FAIL_MAX   = 3'(MAX_FAILS);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_UNLOCKED, S_PROG, S_LOCKOUT} state_t;

  state_t        state, state_nxt;
  logic          enter_q1, enter_q2;
  logic [2:0]    digit_q;
  logic [2:0]    idx, idx_nxt;
  logic          mism, mism_nxt;
  logic [2:0]    fail_cnt, fail_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] code, code_nxt;
  logic [CW-1:0] shadow, shadow_nxt, shadow_w;
  logic          error_q, error_nxt;
  logic          accept, clear, prog, digit_bad, last, store;
  logic [4:0]    off;
  logic          relock_hit;

  assign accept = enter_q1 & ~enter_q2;
  assign clear  = pins.io_in[7];
  assign prog   = pins.io_in[6];
  assign off    = 5'(idx) * 5'd3;
  assign last   = (idx == IDX_LAST);

  // Current digit compared against the live code; shadow_w is the shadow with the
  // incoming digit dropped into its slot, so the final digit commits in one step.
  always_comb begin
    digit_bad = (code[off +: 3] != digit_q);
    shadow_w  = shadow;
    shadow_w[off +: 3] = digit_q;
  end

`ifdef AUTO_RELOCK_EN
  localparam int            RW          = $clog2(RELOCK_CYCLES + 1);
  localparam logic [RW-1:0] RELOCK_LAST = RW'(RELOCK_CYCLES - 1);
  logic [RW-1:0] relock_cnt, relock_nxt;

  // Counts idle clocks in UNLOCKED; any accept (even an ignored one) restarts it.
  always_comb begin
    relock_nxt = '0;
    relock_hit = 1'b0;
    if (state == S_UNLOCKED && !accept) begin
      relock_nxt = relock_cnt + RW'(1);
      relock_hit = (relock_cnt == RELOCK_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) relock_cnt <= '0;
    else        relock_cnt <= relock_nxt;
  end
`else
  assign relock_hit = 1'b0;
  // RELOCK_CYCLES only matters when auto-relock is built in.
  logic unused_relock;
  assign unused_relock = ^32'(RELOCK_CYCLES);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      enter_q1 <= 1'b1;   // a button held through reset must not look like a new press
      enter_q2 <= 1'b1;
      digit_q  <= '0;
      idx      <= '0;
      mism     <= 1'b0;
      fail_cnt <= '0;
      timer    <= '0;
      code     <= RESET_CODE;
      shadow   <= '0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      enter_q1 <= pins.io_in[5];
      enter_q2 <= enter_q1;
      digit_q  <= pins.io_in[4:2];
      idx      <= idx_nxt;
      mism     <= mism_nxt;
      fail_cnt <= fail_nxt;
      timer    <= timer_nxt;
      code     <= code_nxt;
      shadow   <= shadow_nxt;
      error_q  <= error_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    mism_nxt   = mism;
    fail_nxt   = fail_cnt;
    timer_nxt  = timer;
    code_nxt   = code;
    shadow_nxt = shadow;
    error_nxt  = 1'b0;
    store      = 1'b0;
    case (state)
      // IDLE holds idx=0 and mism=0, so it shares the entry path; with CODE_LEN=1
      // the first digit is also the last one and resolves immediately.
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
          mism_nxt  = 1'b0;
        end else if (accept) begin
          if (last) begin
            idx_nxt  = '0;
            mism_nxt = 1'b0;
            if (!(mism | digit_bad)) begin
              state_nxt = S_UNLOCKED;
              fail_nxt  = '0;
            end else begin
              error_nxt = 1'b1;
              if (fail_cnt == FAIL_LAST) begin
                state_nxt = S_LOCKOUT;
                fail_nxt  = FAIL_MAX;
                timer_nxt = TIMER_LOAD;
              end else begin
                state_nxt = S_IDLE;
                fail_nxt  = fail_cnt + 3'd1;
              end
            end
          end else begin
            state_nxt = S_ENTRY;
            idx_nxt   = idx + 3'd1;
            mism_nxt  = mism | digit_bad;
          end
        end
      end
      S_UNLOCKED: begin
        if (clear)                state_nxt = S_IDLE;
        else if (accept && prog)  store = 1'b1;
        else if (relock_hit)      state_nxt = S_IDLE;
      end
      S_PROG: begin
        if (clear) begin
          state_nxt = S_UNLOCKED;
          idx_nxt   = '0;
        end else if (accept) begin
          store = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_nxt = S_IDLE;
          fail_nxt  = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: ;
    endcase

    if (store) begin
      shadow_nxt = shadow_w;
      if (last) begin
        code_nxt  = shadow_w;
        state_nxt = S_UNLOCKED;
        idx_nxt   = '0;
      end else begin
        state_nxt = S_PROG;
        idx_nxt   = idx + 3'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    pins.io_out      = '0;
    pins.io_out[0]   = (state == S_UNLOCKED);
    pins.io_out[1]   = (state == S_LOCKOUT);
    pins.io_out[2]   = (state == S_ENTRY) || (state == S_PROG);
    pins.io_out[3]   = error_q;
    pins.io_out[4]   = (state == S_PROG);
    pins.io_out[7:5] = fail_cnt;
  end
endmodule

// File: tb/tb_combo_lock_sequencer.sv
// Self-checking bench for combo_lock_sequencer: a behavioural model of the lock
// (digit queues, code array, countdowns) is compared with io_out every cycle,
// plus hand-computed literal checks of the key scenarios and a randomized phase.
module tb_combo_lock_sequencer;
  localparam int          CODE_LEN       = 4;
  localparam logic [11:0] RESET_CODE     = 12'b001_010_011_100;
  localparam int          MAX_FAILS      = 3;
  localparam int          LOCKOUT_CYCLES = 16;
  localparam int          RELOCK_CYCLES  = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  combo_lock_sequencer_if pins ();

  combo_lock_sequencer #(
    .CODE_LEN       (CODE_LEN),
    .RESET_CODE     (RESET_CODE),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .RELOCK_CYCLES  (RELOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ENTRY, M_UNLOCKED, M_PROG, M_LOCKOUT} mode_t;
  mode_t m_mode;
  int    attempt[$];
  int    staged[$];
  int    m_code[CODE_LEN];
  int    m_fails;
  int    lock_left;
  bit    m_error;
  bit    e1, e2;
  int    dq;
  bit    model_valid = 1'b0;
`ifdef AUTO_RELOCK_EN
  int    idle_cycles;
`endif

  task automatic model_reset();
    logic [11:0] rc;
    rc = RESET_CODE;
    m_mode = M_IDLE;
    attempt.delete();
    staged.delete();
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'(rc[3*i +: 3]);
    m_fails   = 0;
    lock_left = 0;
    m_error   = 1'b0;
    e1 = 1'b1;
    e2 = 1'b1;
    dq = 0;
`ifdef AUTO_RELOCK_EN
    idle_cycles = 0;
`endif
  endtask

  task automatic stage_digit(int d);
    staged.push_back(d);
    if (staged.size() == CODE_LEN) begin
      for (int i = 0; i < CODE_LEN; i++) m_code[i] = staged[i];
      staged.delete();
      m_mode = M_UNLOCKED;
`ifdef AUTO_RELOCK_EN
      idle_cycles = 0;
`endif
    end else begin
      m_mode = M_PROG;
    end
  endtask

  task automatic model_step(bit acc, int d, bit clr, bit prg);
    bit ok;
    m_error = 1'b0;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (clr) begin
          attempt.delete();
          m_mode = M_IDLE;
        end else if (acc) begin
          attempt.push_back(d);
          if (attempt.size() == CODE_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < CODE_LEN; i++) if (attempt[i] != m_code[i]) ok = 1'b0;
            attempt.delete();
            if (ok) begin
              m_mode  = M_UNLOCKED;
              m_fails = 0;
`ifdef AUTO_RELOCK_EN
              idle_cycles = 0;
`endif
            end else begin
              m_error = 1'b1;
              m_fails++;
              if (m_fails >= MAX_FAILS) begin
                m_fails   = MAX_FAILS;
                m_mode    = M_LOCKOUT;
                lock_left = LOCKOUT_CYCLES;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end else begin
            m_mode = M_ENTRY;
          end
        end
      end
      M_UNLOCKED: begin
        if (clr) m_mode = M_IDLE;
        else if (acc && prg) begin
          staged.delete();
          stage_digit(d);
        end
`ifdef AUTO_RELOCK_EN
        else if (acc) idle_cycles = 0;
        else begin
          idle_cycles++;
          if (idle_cycles == RELOCK_CYCLES) m_mode = M_IDLE;
        end
`endif
      end
      M_PROG: begin
        if (clr) begin
          staged.delete();
          m_mode = M_UNLOCKED;
`ifdef AUTO_RELOCK_EN
          idle_cycles = 0;
`endif
        end else if (acc) stage_digit(d);
      end
      M_LOCKOUT: begin
        lock_left--;
        if (lock_left == 0) begin
          m_mode  = M_IDLE;
          m_fails = 0;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      model_valid = 1'b1;
    end else begin
      model_step(e1 && !e2, dq, pins.io_in[7], pins.io_in[6]);
      e2 = e1;
      e1 = pins.io_in[5];
      dq = int'(pins.io_in[4:2]);
    end
  end

  function automatic logic [7:0] model_out();
    logic [2:0] f;
    f = 3'(m_fails);
    return {f, m_mode == M_PROG, m_error, (m_mode == M_ENTRY) || (m_mode == M_PROG),
            m_mode == M_LOCKOUT, m_mode == M_UNLOCKED};
  endfunction

  // ---------------- checking and stimulus helpers ----------------
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the DUT against the model.
  task automatic tick();
    @(negedge clk);
    if (model_valid) check("io_out vs model", pins.io_out, model_out());
  endtask

  // One enter press; returns once the accepted digit has reached the outputs.
  task automatic press(int d, bit clr);
    pins.io_in[4:2] = 3'(d);
    pins.io_in[5]   = 1'b1;
    tick();
    pins.io_in[5]   = 1'b0;
    pins.io_in[7]   = clr;
    tick();
    pins.io_in[7]   = 1'b0;
  endtask

  task automatic press4(int a, int b, int c, int d);
    press(a, 1'b0);
    press(b, 1'b0);
    press(c, 1'b0);
    press(d, 1'b0);
  endtask

  task automatic pulse_clear();
    pins.io_in[7] = 1'b1;
    tick();
    pins.io_in[7] = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int d;
    bit good;
    pins.io_in = '0;

    // Reset state
    repeat (3) tick();
    check("reset outputs", pins.io_out, 8'h00);
    rst_n = 1'b1;
    tick();

    // Default code 4,3,2,1 unlocks
    press4(4, 3, 2, 1);
    check("default code unlocks", pins.io_out, 8'h01);
    pulse_clear();
    check("clear relocks", pins.io_out, 8'h00);

    // Three wrong attempts then lockout
    press4(0, 0, 0, 0);
    check("first failure", pins.io_out, 8'h28);
    press4(0, 0, 0, 0);
    check("second failure", pins.io_out, 8'h48);
    press4(0, 0, 0, 0);
    check("third failure locks out", pins.io_out, 8'h6A);
    cnt = 0;
    while (pins.io_out[1] && cnt < 100) begin
      cnt++;
      pins.io_in[4:2] = 3'd4;
      pins.io_in[5]   = (cnt < 10) && (cnt % 2 == 1);
      pins.io_in[7]   = (cnt == 5);
      tick();
    end
    pins.io_in[5] = 1'b0;
    pins.io_in[7] = 1'b0;
    check("lockout length", 8'(cnt), 8'(LOCKOUT_CYCLES));
    check("after lockout", pins.io_out, 8'h00);
    press4(4, 3, 2, 1);
    check("unlock after lockout", pins.io_out, 8'h01);

    // Reprogram to 7,7,0,5
    pins.io_in[6] = 1'b1;
    press(7, 1'b0);
    check("prog first digit", pins.io_out, 8'h14);
    press(7, 1'b0);
    press(0, 1'b0);
    press(5, 1'b0);
    check("prog commit", pins.io_out, 8'h01);
    pins.io_in[6] = 1'b0;
    pulse_clear();
    press4(4, 3, 2, 1);
    check("old code rejected", pins.io_out, 8'h28);
    press4(7, 7, 0, 5);
    check("new code unlocks", pins.io_out, 8'h01);

    // Reset in the middle of programming with enter held
    pins.io_in[6] = 1'b1;
    press(1, 1'b0);
    press(2, 1'b0);
    check("mid prog", pins.io_out, 8'h14);
    pins.io_in[5] = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("reset with enter held", pins.io_out, 8'h00);
    pins.io_in[6] = 1'b0;
    pins.io_in[5] = 1'b0;
    tick();
    tick();
    check("no digit after reset", pins.io_out, 8'h00);
    press4(4, 3, 2, 1);
    check("code back to default", pins.io_out, 8'h01);

    // Clear aborts entry, and wins over a simultaneous accept
    pulse_clear();
    press(4, 1'b0);
    press(3, 1'b0);
    check("partial entry busy", pins.io_out, 8'h04);
    pulse_clear();
    check("clear aborts entry", pins.io_out, 8'h00);
    press(4, 1'b0);
    press(3, 1'b0);
    press(2, 1'b1);
    check("clear beats accept", pins.io_out, 8'h00);
    press4(4, 3, 2, 1);
    check("unlock after abort", pins.io_out, 8'h01);

    // Relock behaviour
`ifdef AUTO_RELOCK_EN
    cnt = 0;
    while (pins.io_out[0] && cnt < 300) begin
      cnt++;
      tick();
    end
    check("auto relock time", 8'(cnt), 8'(RELOCK_CYCLES));
`else
    repeat (200) tick();
    check("stays unlocked", pins.io_out, 8'h01);
`endif
    pulse_clear();

    // Randomized attempts, programming, clears and resets
    for (int a = 0; a < 150; a++) begin
      if ($urandom_range(0, 39) == 0) begin
        pins.io_in[5] = 1'($urandom_range(0, 1));
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        pins.io_in[5] = 1'b0;
        tick();
      end
      pins.io_in[6] = ($urandom_range(0, 3) == 0);
      good = 1'($urandom_range(0, 1));
      for (int j = 0; j < CODE_LEN; j++) begin
        d = good ? m_code[j] : int'($urandom_range(0, 7));
        press(d, $urandom_range(0, 19) == 0);
        repeat ($urandom_range(0, 2)) tick();
      end
      if ($urandom_range(0, 5) == 0) pulse_clear();
    end
    pins.io_in = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
